// File: rtl/plru_assoc_cache.sv
// N-way set-associative write-back / write-allocate cache with tree pseudo-LRU
// replacement. CPU side: valid/ready request, one-cycle response pulse.
// Memory side: line request handshake, then WORDS_PER_LINE writeback/fill beats.
module plru_assoc_cache #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_rsp_valid,
  output logic              cpu_rsp_hit,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int NODES = NUM_WAYS - 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, RESPOND
  } state_t;

  state_t state, nextState;

  logic [WORD_W-1:0]   dataArr  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
  logic [TAG_W-1:0]    tagArr   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] validArr [NUM_SETS];
  logic [NUM_WAYS-1:0] dirtyArr [NUM_SETS];
  logic [NODES-1:0]    plruArr  [NUM_SETS];

  logic                reqWe;
  logic [TAG_W-1:0]    reqTag;
  logic [IDX_W-1:0]    reqIdx;
  logic [OFF_W-1:0]    reqOff;
  logic [WORD_W-1:0]   reqWdata;
  logic [WAY_W-1:0]    victimWay;
  logic [OFF_W-1:0]    beat;
  logic                rspHit;
  logic [WORD_W-1:0]   rspData;

  logic [NUM_WAYS-1:0] hitVec;
  logic                anyHit;
  logic [WAY_W-1:0]    hitWay;
  logic [WAY_W-1:0]    pickWay;
  logic                lastBeat;
  logic                accept;
  logic [TAG_W-1:0]    memTag;

  // Point every node on the path to 'way' away from it.
  function automatic logic [NODES-1:0] plruTouch(input logic [NODES-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [NODES-1:0] res;
    int unsigned      node;
    logic             dir;
    res  = bits;
    node = 0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      dir       = way[WAY_W-1-lvl];
      res[node] = ~dir;
      node      = 2 * node + 1 + 32'(dir);
    end
    return res;
  endfunction

  // Follow the tree from the root: 0 = lower half, 1 = upper half.
  function automatic logic [WAY_W-1:0] plruVictim(input logic [NODES-1:0] bits);
    logic [WAY_W-1:0] way;
    int unsigned      node;
    logic             dir;
    way  = '0;
    node = 0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      dir                = bits[node];
      way[WAY_W-1-lvl]   = dir;
      node               = 2 * node + 1 + 32'(dir);
    end
    return way;
  endfunction

  assign accept   = cpu_req_valid && cpu_req_ready;
  assign lastBeat = (beat == OFF_W'(WORDS_PER_LINE - 1));
  assign anyHit   = |hitVec;

  // Tag compare across the latched set and victim choice (invalid first, then PLRU).
  always_comb begin
    hitVec  = '0;
    hitWay  = '0;
    pickWay = plruVictim(plruArr[reqIdx]);
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (validArr[reqIdx][w] && (tagArr[reqIdx][w] == reqTag)) begin
        hitVec[w] = 1'b1;
        hitWay    = WAY_W'(w);
      end
    end
    for (int unsigned w = NUM_WAYS; w > 0; w--) begin
      if (!validArr[reqIdx][w-1]) pickWay = WAY_W'(w - 1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (accept) nextState = LOOKUP;
      LOOKUP: begin
        if (anyHit)
          nextState = RESPOND;
        else if (validArr[reqIdx][pickWay] && dirtyArr[reqIdx][pickWay])
          nextState = WB_REQ;
        else
          nextState = FILL_REQ;
      end
      WB_REQ:    if (mem_req_ready) nextState = WB_DATA;
      WB_DATA:   if (mem_wready && lastBeat) nextState = FILL_REQ;
      FILL_REQ:  if (mem_req_ready) nextState = FILL_DATA;
      FILL_DATA: if (mem_rvalid && lastBeat) nextState = RESPOND;
      RESPOND:   nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Output decode; everything is derived from the async-reset state, so reset
  // drops the memory-side valids immediately.
  always_comb begin
    memTag        = (state == WB_REQ) ? tagArr[reqIdx][victimWay] : reqTag;
    cpu_req_ready = (state == IDLE) && reset_L;
    cpu_rsp_valid = (state == RESPOND);
    cpu_rsp_hit   = (state == RESPOND) && rspHit;
    cpu_rdata     = (state == RESPOND) ? rspData : '0;
    mem_req_valid = (state == WB_REQ) || (state == FILL_REQ);
    mem_we        = (state == WB_REQ);
    mem_addr      = mem_req_valid ? {memTag, reqIdx, OFF_W'(0)} : '0;
    mem_wvalid    = (state == WB_DATA);
    mem_wdata     = (state == WB_DATA) ? dataArr[reqIdx][victimWay][beat] : '0;
  end

  // Request latch, valid/dirty/PLRU state, beat counter and response registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        validArr[s] <= '0;
        dirtyArr[s] <= '0;
        plruArr[s]  <= '0;
      end
      reqWe     <= 1'b0;
      reqTag    <= '0;
      reqIdx    <= '0;
      reqOff    <= '0;
      reqWdata  <= '0;
      victimWay <= '0;
      beat      <= '0;
      rspHit    <= 1'b0;
      rspData   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          reqWe    <= cpu_we;
          reqTag   <= cpu_addr[ADDR_W-1 -: TAG_W];
          reqIdx   <= cpu_addr[OFF_W +: IDX_W];
          reqOff   <= cpu_addr[OFF_W-1:0];
          reqWdata <= cpu_wdata;
        end
        LOOKUP: begin
          if (anyHit) begin
            plruArr[reqIdx] <= plruTouch(plruArr[reqIdx], hitWay);
            rspHit          <= 1'b1;
            rspData         <= reqWe ? '0 : dataArr[reqIdx][hitWay][reqOff];
            if (reqWe) dirtyArr[reqIdx][hitWay] <= 1'b1;
          end else begin
            victimWay <= pickWay;
            rspHit    <= 1'b0;
            beat      <= '0;
          end
        end
        WB_REQ: if (mem_req_ready) beat <= '0;
        WB_DATA: if (mem_wready) beat <= beat + 1'b1;
        FILL_REQ: if (mem_req_ready) begin
          beat                        <= '0;
          validArr[reqIdx][victimWay] <= 1'b0;
        end
        FILL_DATA: if (mem_rvalid) begin
          beat <= beat + 1'b1;
          if (lastBeat) begin
            validArr[reqIdx][victimWay] <= 1'b1;
            dirtyArr[reqIdx][victimWay] <= reqWe;
            plruArr[reqIdx]             <= plruTouch(plruArr[reqIdx], victimWay);
            // The requested word may be the beat arriving right now.
            if (reqWe)                rspData <= '0;
            else if (reqOff == beat)  rspData <= mem_rdata;
            else                      rspData <= dataArr[reqIdx][victimWay][reqOff];
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag storage; a write-miss merge lands after the last fill beat so it wins.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && anyHit && reqWe)
      dataArr[reqIdx][hitWay][reqOff] <= reqWdata;
    if (state == FILL_DATA && mem_rvalid) begin
      dataArr[reqIdx][victimWay][beat] <= mem_rdata;
      if (lastBeat) begin
        tagArr[reqIdx][victimWay] <= reqTag;
        if (reqWe) dataArr[reqIdx][victimWay][reqOff] <= reqWdata;
      end
    end
  end

  // At most one way may match a tag.
  always_ff @(posedge clk) begin
    if (reset_L && state == LOOKUP) assert ($onehot0(hitVec));
  end

endmodule

// File: tb/tb_plru_assoc_cache.sv
// Directed bench for plru_assoc_cache: table of requests with hand-computed
// results, a cycle-stepped memory responder, and reset / abort sequences.
module tb_plru_assoc_cache;
  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_hit;
  logic [15:0] cpu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic [15:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;

  always #5 clk = ~clk;

  plru_assoc_cache #(
    .ADDR_W(16), .WORD_W(16), .WORDS_PER_LINE(4), .NUM_SETS(16), .NUM_WAYS(4)
  ) dut (
    .clk(clk), .reset_L(reset_L),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_hit(cpu_rsp_hit), .cpu_rdata(cpu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          stall;
    logic        toggle;
    logic        expHit;
    logic [15:0] expData;
    int          expReqs;
    logic        expWe0;
    logic [15:0] expAddr0;
    logic [15:0] expAddr1;
    logic [15:0] expWb1;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  logic [15:0] memArr [0:1023];
  int          nCmp = 0;
  int          nErr = 0;

  int          reqCnt;
  logic        reqWeLog   [4];
  logic [15:0] reqAddrLog [4];
  logic [15:0] wbLog      [4];
  int          wbCnt;
  int          stabErr;
  logic        gotHit;
  logic [15:0] gotData;
  int          gotCycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearMemIn();
    mem_req_ready = 1'b0;
    mem_wready    = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
  endtask

  task automatic chkQuiet(input string tag);
    chk({tag, " ctrl"}, 32'({cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit,
                             mem_req_valid, mem_we, mem_wvalid}), 32'd0);
    chk({tag, " buses"}, {mem_addr, cpu_rdata | mem_wdata}, 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_L       = 1'b0;
    cpu_req_valid = 1'b0;
    clearMemIn();
    #1;
    chkQuiet("reset");
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    #1;
    chk("reset ready", 32'(cpu_req_ready), 32'd1);
  endtask

  // Issue one request and play the memory until the response (or abort).
  task automatic runReq(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int stallCfg, input logic toggle, input int abortBeats);
    int          cycles, stall, fillCnt;
    logic        reqSeen, fillActive, prevStalled, wTog;
    logic [15:0] holdAddr, fillBase, wbBase, prevW;
    reqCnt = 0; wbCnt = 0; stabErr = 0; gotHit = 1'b0; gotData = '0; gotCycles = -1;
    fillActive = 1'b0; fillCnt = 0; reqSeen = 1'b0; prevStalled = 1'b0; wTog = 1'b0;
    stall = 0; holdAddr = '0; fillBase = '0; wbBase = '0; prevW = '0;
    cycles = 0;
    @(negedge clk);
    while (!cpu_req_ready && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!cpu_req_ready) begin
      nCmp++; nErr++;
      $display("FAIL req_ready timeout: got 0 expected 1");
      return;
    end
    cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cycles = 0;
    while (cycles < 300) begin
      @(negedge clk);
      cycles++;
      clearMemIn();
      if (cpu_rsp_valid) begin
        gotHit = cpu_rsp_hit; gotData = cpu_rdata; gotCycles = cycles;
        break;
      end
      if (mem_req_valid) begin
        if (!reqSeen) begin
          reqSeen = 1'b1; holdAddr = mem_addr; stall = stallCfg;
          if (reqCnt < 4) begin
            reqWeLog[reqCnt]   = mem_we;
            reqAddrLog[reqCnt] = mem_addr;
          end
          reqCnt++;
        end else if (mem_addr != holdAddr) begin
          stabErr++;
        end
        if (stall > 0) stall--;
        else begin
          mem_req_ready = 1'b1;
          reqSeen       = 1'b0;
          if (mem_we) wbBase = mem_addr;
          else begin
            fillBase = mem_addr; fillActive = 1'b1; fillCnt = 0;
          end
        end
      end else if (mem_wvalid) begin
        if (prevStalled && mem_wdata != prevW) stabErr++;
        wTog        = toggle ? ~wTog : 1'b1;
        mem_wready  = wTog;
        prevStalled = ~wTog;
        prevW       = mem_wdata;
        if (wTog) begin
          if (wbCnt < 4) wbLog[wbCnt] = mem_wdata;
          memArr[(int'(wbBase) + wbCnt) % 1024] = mem_wdata;
          wbCnt++;
        end
      end else if (fillActive && fillCnt < 4) begin
        if (abortBeats != 0 && fillCnt == abortBeats) begin
          reset_L = 1'b0;
          #1;
          chkQuiet("abort");
          gotCycles = 0;
          return;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = memArr[(int'(fillBase) + fillCnt) % 1024];
        fillCnt++;
      end
    end
    if (gotCycles < 0) begin
      nCmp++; nErr++;
      $display("FAIL rsp timeout addr %0h: got none expected rsp_valid", addr);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) memArr[a] = 16'hC000 + 16'(a);
    memArr[16] = 16'h00A0; memArr[17] = 16'h00A1;
    memArr[18] = 16'h00A2; memArr[19] = 16'h00A3;

    //         rst we  addr      wdata    st tg hit data      rq we0 addr0     addr1     wb1
    vecs[0]  = '{1, 0, 16'h0012, 16'h0000, 0, 0, 0, 16'h00A2, 1, 0, 16'h0010, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 0, 16'h0012, 16'h0000, 0, 0, 1, 16'h00A2, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{0, 1, 16'h0013, 16'h1234, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[3]  = '{0, 0, 16'h0013, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[4]  = '{0, 0, 16'h0010, 16'h0000, 0, 0, 1, 16'h00A0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[5]  = '{1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hC000, 1, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[6]  = '{0, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'hC040, 1, 0, 16'h0040, 16'h0000, 16'h0000};
    vecs[7]  = '{0, 0, 16'h0080, 16'h0000, 0, 0, 0, 16'hC080, 1, 0, 16'h0080, 16'h0000, 16'h0000};
    vecs[8]  = '{0, 0, 16'h00C0, 16'h0000, 0, 0, 0, 16'hC0C0, 1, 0, 16'h00C0, 16'h0000, 16'h0000};
    vecs[9]  = '{0, 0, 16'h0100, 16'h0000, 0, 0, 0, 16'hC100, 1, 0, 16'h0100, 16'h0000, 16'h0000};
    vecs[10] = '{0, 0, 16'h0040, 16'h0000, 0, 0, 1, 16'hC040, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[11] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hC000, 1, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[12] = '{0, 0, 16'h00C0, 16'h0000, 0, 0, 1, 16'hC0C0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[13] = '{0, 0, 16'h0080, 16'h0000, 0, 0, 0, 16'hC080, 1, 0, 16'h0080, 16'h0000, 16'h0000};
    vecs[14] = '{1, 1, 16'h0001, 16'hBEEF, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[15] = '{0, 0, 16'h0001, 16'h0000, 0, 0, 1, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[16] = '{0, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'hC040, 1, 0, 16'h0040, 16'h0000, 16'h0000};
    vecs[17] = '{0, 0, 16'h0080, 16'h0000, 0, 0, 0, 16'hC080, 1, 0, 16'h0080, 16'h0000, 16'h0000};
    vecs[18] = '{0, 0, 16'h00C0, 16'h0000, 0, 0, 0, 16'hC0C0, 1, 0, 16'h00C0, 16'h0000, 16'h0000};
    vecs[19] = '{0, 0, 16'h0100, 16'h0000, 5, 1, 0, 16'hC100, 2, 1, 16'h0000, 16'h0100, 16'hBEEF};
    vecs[20] = '{0, 0, 16'h0001, 16'h0000, 0, 0, 0, 16'hBEEF, 1, 0, 16'h0000, 16'h0000, 16'h0000};

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) doReset();
      runReq(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall, vecs[i].toggle, 0);
      chk($sformatf("v%0d hit", i),   32'(gotHit),  32'(vecs[i].expHit));
      chk($sformatf("v%0d rdata", i), 32'(gotData), 32'(vecs[i].expData));
      chk($sformatf("v%0d memreqs", i), reqCnt, vecs[i].expReqs);
      chk($sformatf("v%0d stable", i), stabErr, 0);
      if (vecs[i].expHit) chk($sformatf("v%0d latency", i), gotCycles, 2);
      if (vecs[i].expReqs > 0) begin
        chk($sformatf("v%0d req0 we", i),   32'(reqWeLog[0]),   32'(vecs[i].expWe0));
        chk($sformatf("v%0d req0 addr", i), 32'(reqAddrLog[0]), 32'(vecs[i].expAddr0));
      end
      if (vecs[i].expReqs > 1) begin
        chk($sformatf("v%0d req1 we", i),   32'(reqWeLog[1]),   32'd0);
        chk($sformatf("v%0d req1 addr", i), 32'(reqAddrLog[1]), 32'(vecs[i].expAddr1));
        chk($sformatf("v%0d wb beats", i),  wbCnt, 4);
        chk($sformatf("v%0d wb beat0", i),  32'(wbLog[0]), 32'h0000C000);
        chk($sformatf("v%0d wb beat1", i),  32'(wbLog[1]), 32'(vecs[i].expWb1));
        chk($sformatf("v%0d wb beat3", i),  32'(wbLog[3]), 32'h0000C003);
      end else begin
        chk($sformatf("v%0d no wb", i), wbCnt, 0);
      end
    end

    // Reset in the middle of a fill, then the same address must miss again.
    doReset();
    runReq(1'b0, 16'h0012, 16'h0000, 0, 1'b0, 2);
    chk("abort reached", gotCycles, 0);
    doReset();
    runReq(1'b0, 16'h0012, 16'h0000, 0, 1'b0, 0);
    chk("refetch hit",   32'(gotHit),  32'd0);
    chk("refetch rdata", 32'(gotData), 32'h000000A2);
    chk("refetch reqs",  reqCnt, 1);
    chk("refetch addr",  32'(reqAddrLog[0]), 32'h00000010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
